// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo counter family.
// Also used by the BCD and time-of-day counters built from these counters.
package counter_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    // Number of bits needed to hold the values 0..modulus-1 (at least one bit).
    function automatic int mod_width(input int modulus);
        int w;
        w = 1;
        while ((64'(1) << w) < 64'(modulus)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/mod_counter_step.sv
// Combinational next-count logic for one modulo-M stage.
// Computes the next value and flags when the count sits on the terminal value for the current direction.
module mod_counter_step
    import counter_pkg::*;
#(
    parameter int N        = 8,
    parameter int MODULUS  = 6,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic [N-1:0] q,
    input  logic         up,
    output logic [N-1:0] next_q,
    output logic         at_tc
);

    localparam logic [N:0] LAST = (N+1)'(MODULUS - 1);

    logic [N:0] q_ext;
    logic [N:0] tv;
    logic [N:0] sum;

    // One extra bit keeps MODULUS == 2**N exact.
    always_comb begin
        q_ext = {1'b0, q};
        tv    = (up == DIR_UP) ? LAST : '0;
        at_tc = (q_ext == tv);
        sum   = q_ext;
        if (!at_tc) begin
            sum = (up == DIR_UP) ? q_ext + 1'b1 : q_ext - 1'b1;
        end else if (SATURATE != MODE_SAT) begin
            sum = (up == DIR_UP) ? '0 : LAST;
        end
        next_q = sum[N-1:0];
    end

endmodule

// File: rtl/mod_counter.sv
// Modulo-M up/down counter with clamped parallel load, wrap or saturate mode,
// a cascadable terminal count and a sticky overflow flag.
module mod_counter
    import counter_pkg::*;
#(
    parameter int N        = 8,
    parameter int MODULUS  = 6,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] d,
    input  logic         clr_ovf,
    output logic [N-1:0] q,
    output logic         tc,
    output logic         ovf
);

    localparam logic [N:0]   MOD_EXT = (N+1)'(MODULUS);
    localparam logic [N-1:0] LAST_N  = N'(MODULUS - 1);

    if (MODULUS < 2 || mod_width(MODULUS) > N) begin : g_bad_modulus
        $error("mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**N");
    end

    logic [N-1:0] step_q;
    logic         at_tc;
    logic [N-1:0] load_val;
    logic         started;

    mod_counter_step #(
        .N        (N),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_step (
        .q      (q),
        .up     (up),
        .next_q (step_q),
        .at_tc  (at_tc)
    );

    assign load_val = ({1'b0, d} < MOD_EXT) ? d : LAST_N;
    assign tc       = en & ~load & at_tc;

    // started keeps q and ovf parked at zero through the first edge after clear is released.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q       <= '0;
            ovf     <= 1'b0;
            started <= 1'b0;
        end else if (!started) begin
            started <= 1'b1;
        end else begin
            if (load) begin
                q <= load_val;
            end else if (en) begin
                q <= step_q;
            end
            if (en && !load && at_tc) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: wrap, saturate, M=256 and a two-digit cascade,
// compared every cycle against an arithmetic model plus hand-computed checkpoints.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       en, up, load, clr_ovf;
    logic [7:0] d;
    logic       c_en, c_load;
    logic [7:0] c_du, c_dt;

    // Instances: 0 wrap M=6, 1 saturate M=6, 2 wrap M=256, 3 cascade units, 4 cascade tens.
    logic [7:0] aq  [5];
    logic       atc [5];
    logic       aov [5];

    int mods [5] = '{6, 6, 256, 10, 10};
    bit sats [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int mq   [5] = '{0, 0, 0, 0, 0};
    bit mo   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bit held = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mod_counter #(.N(8), .MODULUS(6), .SATURATE(0)) u_main (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .d(d), .clr_ovf(clr_ovf),
        .q(aq[0]), .tc(atc[0]), .ovf(aov[0]));
    mod_counter #(.N(8), .MODULUS(6), .SATURATE(1)) u_sat (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .d(d), .clr_ovf(clr_ovf),
        .q(aq[1]), .tc(atc[1]), .ovf(aov[1]));
    mod_counter #(.N(8), .MODULUS(256), .SATURATE(0)) u_wide (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .d(d), .clr_ovf(clr_ovf),
        .q(aq[2]), .tc(atc[2]), .ovf(aov[2]));
    mod_counter #(.N(8), .MODULUS(10), .SATURATE(0)) u_units (
        .clk(clk), .clear(clear), .en(c_en), .up(1'b1), .load(c_load), .d(c_du), .clr_ovf(1'b0),
        .q(aq[3]), .tc(atc[3]), .ovf(aov[3]));
    mod_counter #(.N(8), .MODULUS(10), .SATURATE(0)) u_tens (
        .clk(clk), .clear(clear), .en(atc[3]), .up(1'b1), .load(c_load), .d(c_dt), .clr_ovf(1'b0),
        .q(aq[4]), .tc(atc[4]), .ovf(aov[4]));

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit e, input bit u, input bit l, input logic [7:0] dv,
                                 input bit c, input int cycles);
        en = e; up = u; load = l; d = dv; clr_ovf = c;
        repeat (cycles) @(negedge clk);
        #1;
    endtask

    function automatic bit model_tc(input int i, input bit e, input bit u, input bit l);
        return e && !l && (mq[i] == (u ? mods[i] - 1 : 0));
    endfunction

    task automatic get_in(input int i, output bit e, output bit u, output bit l,
                          output int dv, output bit c);
        case (i)
            0, 1, 2: begin e = en;   u = up;   l = load;   dv = int'(d);    c = clr_ovf; end
            3:       begin e = c_en; u = 1'b1; l = c_load; dv = int'(c_du); c = 1'b0;    end
            default: begin e = model_tc(3, c_en, 1'b1, c_load);
                           u = 1'b1; l = c_load; dv = int'(c_dt); c = 1'b0; end
        endcase
    endtask

    // Model: modular arithmetic on the counts, all stages evaluated from the pre-edge state.
    always @(posedge clk or negedge clear) begin
        int nq [5];
        bit no [5];
        bit e, u, l, c, term;
        int dv;
        if (!clear) begin
            for (int i = 0; i < 5; i++) begin
                mq[i] = 0;
                mo[i] = 1'b0;
            end
            held = 1'b1;
        end else if (held) begin
            held = 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                get_in(i, e, u, l, dv, c);
                term  = (mq[i] == (u ? mods[i] - 1 : 0));
                nq[i] = mq[i];
                if (l) begin
                    nq[i] = (dv < mods[i]) ? dv : mods[i] - 1;
                end else if (e && !(term && sats[i])) begin
                    nq[i] = u ? (mq[i] + 1) % mods[i] : (mq[i] + mods[i] - 1) % mods[i];
                end
                no[i] = (!l && e && term) ? 1'b1 : (c ? 1'b0 : mo[i]);
            end
            for (int i = 0; i < 5; i++) begin
                mq[i] = nq[i];
                mo[i] = no[i];
            end
        end
    end

    always @(negedge clk) begin
        bit e, u, l, c;
        int dv;
        for (int i = 0; i < 5; i++) begin
            get_in(i, e, u, l, dv, c);
            checkOutput($sformatf("model_q[%0d]", i), 32'(aq[i]), 32'(mq[i]));
            checkOutput($sformatf("model_ovf[%0d]", i), 32'(aov[i]), 32'(mo[i]));
            checkOutput($sformatf("model_tc[%0d]", i), 32'(atc[i]), 32'(model_tc(i, e, u, l)));
        end
    end

    initial begin
        en = 0; up = 1; load = 0; d = 0; clr_ovf = 0;
        c_en = 0; c_load = 0; c_du = 0; c_dt = 0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_q", 32'(aq[0]), 0);
        checkOutput("reset_ovf", 32'(aov[0]), 0);

        // Count up from reset; the first edge after release must not count.
        clear = 1'b1;
        applyStimulus(1, 1, 0, 8'd0, 0, 1);
        checkOutput("hold_after_release", 32'(aq[0]), 0);
        applyStimulus(1, 1, 0, 8'd0, 0, 5);
        checkOutput("wrap_up_q5", 32'(aq[0]), 5);
        checkOutput("wrap_up_tc", 32'(atc[0]), 1);
        checkOutput("wrap_up_ovf_pre", 32'(aov[0]), 0);
        applyStimulus(1, 1, 0, 8'd0, 0, 1);
        checkOutput("wrap_up_q0", 32'(aq[0]), 0);
        checkOutput("wrap_up_ovf", 32'(aov[0]), 1);
        checkOutput("sat_up_hold", 32'(aq[1]), 5);

        // Set and clear in the same cycle: set wins on the saturating stage.
        applyStimulus(1, 1, 0, 8'd0, 1, 1);
        checkOutput("clr_only_main", 32'(aov[0]), 0);
        checkOutput("set_wins_sat", 32'(aov[1]), 1);
        applyStimulus(0, 1, 0, 8'd0, 1, 1);
        checkOutput("clr_ovf_sat", 32'(aov[1]), 0);

        // Count down through zero.
        applyStimulus(1, 0, 1, 8'd0, 0, 1);
        checkOutput("load_zero", 32'(aq[0]), 0);
        applyStimulus(1, 0, 0, 8'd0, 0, 1);
        checkOutput("wrap_down_q", 32'(aq[0]), 5);
        checkOutput("sat_down_q", 32'(aq[1]), 0);
        checkOutput("sat_down_tc", 32'(atc[1]), 1);
        checkOutput("sat_down_ovf", 32'(aov[1]), 1);
        checkOutput("wide_down_q", 32'(aq[2]), 255);

        // Direction change at zero, and the M=256 wrap.
        applyStimulus(0, 1, 0, 8'd0, 1, 1);
        applyStimulus(1, 1, 0, 8'd0, 0, 1);
        checkOutput("dir_change_q", 32'(aq[1]), 1);
        checkOutput("dir_change_ovf", 32'(aov[1]), 0);
        checkOutput("wide_wrap_q", 32'(aq[2]), 0);
        checkOutput("wide_wrap_ovf", 32'(aov[2]), 1);

        // Load priority and clamp.
        applyStimulus(1, 1, 1, 8'd3, 0, 1);
        checkOutput("load_priority", 32'(aq[0]), 3);
        applyStimulus(0, 1, 1, 8'd9, 0, 1);
        checkOutput("load_clamp", 32'(aq[0]), 5);
        checkOutput("load_wide", 32'(aq[2]), 9);
        en = 1; up = 1; load = 1; d = 8'd2;
        #1;
        checkOutput("load_masks_tc", 32'(atc[0]), 0);
        applyStimulus(1, 1, 1, 8'd2, 0, 1);
        checkOutput("load_at_tv_q", 32'(aq[0]), 2);
        checkOutput("load_keeps_ovf", 32'(aov[0]), 1);

        // Asynchronous reset between edges.
        applyStimulus(0, 1, 1, 8'd4, 0, 1);
        checkOutput("pre_reset_q", 32'(aq[0]), 4);
        en = 1; up = 1; load = 0;
        #1 clear = 1'b0;
        #1;
        checkOutput("async_reset_q", 32'(aq[0]), 0);
        checkOutput("async_reset_ovf", 32'(aov[0]), 0);
        @(negedge clk);
        #1 clear = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("reset_release_hold", 32'(aq[0]), 0);
        @(negedge clk);
        #1;
        checkOutput("reset_release_count", 32'(aq[0]), 1);

        // Two-digit cascade: 99 rolls to 00.
        en = 0;
        c_load = 1; c_du = 8'd9; c_dt = 8'd9;
        @(negedge clk);
        #1;
        checkOutput("casc_units_9", 32'(aq[3]), 9);
        checkOutput("casc_tens_9", 32'(aq[4]), 9);
        c_load = 0; c_en = 1;
        #1;
        checkOutput("casc_tens_tc", 32'(atc[4]), 1);
        @(negedge clk);
        #1;
        checkOutput("casc_units_0", 32'(aq[3]), 0);
        checkOutput("casc_tens_0", 32'(aq[4]), 0);
        checkOutput("casc_tens_ovf", 32'(aov[4]), 1);
        repeat (12) @(negedge clk);
        #1;
        checkOutput("casc_units_12", 32'(aq[3]), 2);
        checkOutput("casc_tens_12", 32'(aq[4]), 1);

        c_en = 0;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
